// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared width constants for the CPU datapath blocks
package cpu_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int BUS_WIDTH  = DATA_WIDTH;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - loadable, incrementing program counter with tri-state bus output
module program_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             oe,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] pc_value
);

  logic [WIDTH-1:0] count;

  // Load outranks increment; data_in is only looked at when ld is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (ld) begin
      count <= data_in;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign pc_value = count;
  assign data_out = oe ? count : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic       oe;
  logic [3:0] data_in;
  wire  [3:0] data_out;
  logic [3:0] pc_value;

  logic [3:0] model_count;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  int         vectors;
  int         miscompares;

  program_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .oe       (oe),
    .data_in  (data_in),
    .data_out (data_out),
    .pc_value (pc_value)
  );

  // Weak pull-ups make an undriven bus read as all ones.
  for (genvar i = 0; i < 4; i++) begin : g_pull
    pullup (data_out[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_cycle(input logic r, input logic e, input logic l, input logic [3:0] d);
    @(negedge clk);
    rst     = r;
    en      = e;
    ld      = l;
    data_in = d;
    if (!r)      model_count = 4'h0;
    else if (l)  model_count = d;
    else if (e)  model_count = model_count + 4'h1;
    exp_q.push_back(model_count);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expected(output logic [3:0] v);
    if (exp_q.size() == 0) v = 4'hx;
    else v = exp_q.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; ld = 1'b1; oe = 1'b0; data_in = 4'h7;
    model_count = 4'h0;
    #2;
    vectors++;
    if (pc_value !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h want 0", pc_value);
    end
    vectors++;
    if (data_out !== 4'hF && data_out !== 4'bzzzz) begin
      miscompares++;
      $display("FAIL reset_bus_z: got %b want released", data_out);
    end
    oe = 1'b1;
    #1;
    vectors++;
    if (data_out !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_bus_oe: got %h want 0", data_out);
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 4'h7);
    pop_expected(exp_v);
    vectors++;
    if (pc_value !== exp_v) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", pc_value, exp_v);
    end
    oe = 1'b0;
  endtask

  task automatic test_count;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 4'h0);
      pop_expected(exp_v);
      vectors++;
      if (pc_value !== exp_v) begin
        miscompares++;
        $display("FAIL count_step%0d: got %h want %h", i, pc_value, exp_v);
      end
    end
    en = 1'b0;
    oe = 1'b1;
    #1;
    vectors++;
    if (data_out !== 4'h5) begin
      miscompares++;
      $display("FAIL count_bus: got %h want 5", data_out);
    end
  endtask

  task automatic test_hold_tristate;
    oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 4'h0);
      pop_expected(exp_v);
      vectors++;
      if (pc_value !== exp_v) begin
        miscompares++;
        $display("FAIL hold_pc%0d: got %h want %h", i, pc_value, exp_v);
      end
      vectors++;
      if (data_out !== 4'hF && data_out !== 4'bzzzz) begin
        miscompares++;
        $display("FAIL hold_bus_z%0d: got %b want released", i, data_out);
      end
    end
    oe = 1'b1;
    #1;
    vectors++;
    if (data_out !== 4'h5) begin
      miscompares++;
      $display("FAIL hold_bus_oe: got %h want 5", data_out);
    end
  endtask

  task automatic test_async_reset;
    // Just past an edge, well before the next one.
    #2;
    rst = 1'b0;
    model_count = 4'h0;
    #1;
    vectors++;
    if (pc_value !== 4'h0) begin
      miscompares++;
      $display("FAIL async_clear: got %h want 0", pc_value);
    end
    vectors++;
    if (data_out !== 4'h0) begin
      miscompares++;
      $display("FAIL async_bus: got %h want 0", data_out);
    end
    oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 4'h0);
      pop_expected(exp_v);
      vectors++;
      if (pc_value !== exp_v) begin
        miscompares++;
        $display("FAIL async_recount%0d: got %h want %h", i, pc_value, exp_v);
      end
    end
  endtask

  task automatic test_wrap;
    drive_cycle(1'b1, 1'b0, 1'b1, 4'hE);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 4'h0);
    // Cycles were driven back to back; check the queue order afterwards too.
    for (int i = 0; i < 4; i++) begin
      pop_expected(exp_v);
      vectors++;
      if (exp_v !== (4'hE + i[3:0])) begin
        miscompares++;
        $display("FAIL wrap_model%0d: got %h want %h", i, exp_v, 4'hE + i[3:0]);
      end
    end
    vectors++;
    if (pc_value !== 4'h1) begin
      miscompares++;
      $display("FAIL wrap_final: got %h want 1", pc_value);
    end
  endtask

  task automatic test_priority;
    drive_cycle(1'b1, 1'b0, 1'b1, 4'h3);
    pop_expected(exp_v);
    drive_cycle(1'b1, 1'b1, 1'b1, 4'h9);
    pop_expected(exp_v);
    vectors++;
    if (pc_value !== 4'h9) begin
      miscompares++;
      $display("FAIL prio_load: got %h want 9", pc_value);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 4'h9);
    pop_expected(exp_v);
    vectors++;
    if (pc_value !== exp_v) begin
      miscompares++;
      $display("FAIL prio_next: got %h want %h", pc_value, exp_v);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 4'bxxzz);
    pop_expected(exp_v);
    vectors++;
    if (pc_value !== exp_v) begin
      miscompares++;
      $display("FAIL prio_x_data: got %h want %h", pc_value, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    oe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 4'h0);
      pop_expected(exp_v);
      vectors++;
      if (pc_value !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_pc%0d: got %h want %h", i, pc_value, exp_v);
      end
      vectors++;
      if (data_out !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_bus%0d: got %h want %h", i, data_out, exp_v);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_count();
    test_hold_tristate();
    test_async_reset();
    test_wrap();
    test_priority();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter, load-data and bus width in bits.
REQ-002 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port en, input, 1 bit: count enable; increments the counter by one per clock when high.
REQ-005 Port ld, input, 1 bit: load strobe; copies data_in into the counter on the next rising edge.
REQ-006 Port oe, input, 1 bit: output enable; drives the counter value onto data_out.
REQ-007 Port data_in, input, WIDTH bits: parallel load value (jump target).
REQ-008 Port data_out, output, WIDTH bits: tri-state bus output; counter value when oe=1, high-impedance otherwise.
REQ-009 Port pc_value, output, WIDTH bits: always-driven copy of the counter, for debug and observation.

Function
REQ-010 The counter SHALL be a single WIDTH-bit register, count.
REQ-011 On a rising clk edge with rst high, count SHALL take the following next value, in priority order: ld=1 gives data_in; else en=1 gives count+1; else count holds.
REQ-012 When ld and en are both high, the load SHALL win and no increment SHALL occur in that cycle.
REQ-013 Increment SHALL be modulo 2^WIDTH: all-ones wraps to zero with no carry, flag or stall.
REQ-014 data_out SHALL be combinational from count and oe, so it is valid in the same cycle oe rises; it carries no added latency.
REQ-015 When oe=0, data_out SHALL be all high-Z, so several drivers can share the bus.
REQ-016 oe SHALL have no effect on count; reading and counting may occur in the same cycle.
REQ-017 pc_value SHALL equal count at all times, independent of oe.
REQ-018 Load and increment take effect one clock edge after the controlling input is sampled high (latency 1).
REQ-019 X or Z on data_in while ld=0 SHALL NOT affect count.

Reset
REQ-020 rst=0 SHALL force count to zero immediately, without waiting for clk, and SHALL hold it at zero while asserted, regardless of en and ld.
REQ-021 During reset, data_out SHALL follow oe: zero when oe=1, high-Z when oe=0.
REQ-022 After rst rises, the first rising clk edge SHALL apply the normal REQ-011 priority; a reset asserted mid-count discards the count value.
REQ-023 No other state exists; power-up value is irrelevant once rst has been asserted.

Structure
REQ-024 A shared package (cpu_pkg) SHALL hold the default data width constant (4) and the bus width used by the other CPU blocks; program_counter takes WIDTH from it by default.
REQ-025 The block SHALL be implemented as one module with no sub-modules: one register process plus a continuous tri-state assignment.
REQ-026 Tri-state drive SHALL be confined to data_out; no internal tri-state nets.

Verification
REQ-027 Count: clk period 10 ns, rst pulsed low then high, en=1 for 5 cycles, ld=0 -> pc_value steps 0,1,2,3,4,5; oe=1 -> data_out=5.
REQ-028 Hold and tri-state: en=0, oe=0 for 3 cycles -> pc_value stays 5, data_out is all Z; oe=1 -> data_out=5 the same cycle.
REQ-029 Async reset: count=5, rst driven low mid-cycle -> pc_value=0 before the next edge; rst high, en=1 -> 1,2,3 on successive edges.
REQ-030 Wrap: load 14 (data_in=4'hE, ld=1 one cycle), then en=1 -> 14, 15, 0, 1.
REQ-031 Priority: count=3, en=1, ld=1, data_in=9 -> count=9, not 4; next cycle ld=0, en=1 -> 10.
REQ-032 Concurrent read and count: en=1, oe=1 continuously -> data_out tracks pc_value every cycle with zero lag.
